cellrv32_spi_host: RTL
======================

// Module: cellrv32_spi_host
// PURPOSE
//  Bus-mapped SPI host (controller): drives SCK/CSN/MOSI and samples MISO, one byte per transfer, MSB first.
//  Complements the SDI device block: CPU writes a byte, the engine clocks it out and captures the reply.
//  Sits on the processor IO bus next to the other IO devices.
// PARAMETERS
//  BASE_ADDR  32'hFFFF_FFA8  word-aligned base; CTRL at BASE_ADDR+0, DATA at BASE_ADDR+4; all other addresses ignored
// PORTS
//  clk_i      in   1   global clock, rising edge
//  rst_i      in   1   global reset, asynchronous, active-high
//  addr_i     in   32  bus address
//  rden_i     in   1   bus read enable
//  wren_i     in   1   bus write enable
//  data_i     in   32  bus write data
//  data_o     out  32  bus read data
//  ack_o      out  1   transfer acknowledge
//  spi_clk_o  out  1   serial clock
//  spi_csn_o  out  1   chip select, low-active
//  spi_dat_o  out  1   serial data out (MOSI)
//  spi_dat_i  in   1   serial data in (MISO)
//  irq_o      out  1   interrupt, high-active level
// BEHAVIOUR
//  Reset: data_o=0, ack_o=0, spi_clk_o=0, spi_csn_o=1, spi_dat_o=0, irq_o=0, all CTRL bits 0, FSM IDLE.
//  Bus: ack_o=1 exactly one cycle after any rden_i/wren_i hitting CTRL or DATA; data_o=0 except on that cycle.
//  CTRL: [0]EN [1]CPHA [2]CPOL [3]CS_EN [4]IRQ_EN [15:8]CDIV; r/o [30]BUSY [31]RX_VALID; other bits read 0.
//  DATA read: [7:0] = last received byte, [31:8]=0; clears RX_VALID on the same edge as ack_o.
//  spi_csn_o = ~(EN & CS_EN), registered. Chip select is software-managed; engine never toggles it.
//  spi_clk_o idle level = CPOL when EN=1, 0 when EN=0.
//  FSM: IDLE -> LEAD -> TRAIL -> (LEAD | IDLE). Each half-period = CDIV+1 clk cycles (prescaler counter).
//  - IDLE: DATA write with EN=1 latches byte into shift reg, latches CPHA/CPOL/CDIV, bit cnt=0, BUSY=1 next cycle, -> LEAD.
//  - LEAD end: spi_clk_o toggles to ~CPOL; CPHA=0: sample spi_dat_i; CPHA=1: shift out next bit.
//  - TRAIL end: spi_clk_o back to CPOL; CPHA=0: shift; CPHA=1: sample; cnt==7 -> IDLE, else cnt+1, -> LEAD.
//  - CPHA=0: MSB on spi_dat_o from the first BUSY cycle. CPHA=1: MSB driven at the first leading edge.
//  Transfer: BUSY high exactly 16*(CDIV+1) cycles; on the edge BUSY falls, RX_VALID=1 and DATA holds the received byte.
//  spi_dat_o holds the last shifted bit after completion; MISO is sampled directly (host-timed, no synchronizer).
//  Boundaries:
//  - DATA write while BUSY: ignored (acked, no effect on the running transfer or the result).
//  - CTRL write while BUSY: EN/CS_EN/IRQ_EN update immediately; CPHA/CPOL/CDIV stored but used from the next transfer.
//  - EN cleared while BUSY: abort next cycle -> IDLE, BUSY=0, spi_clk_o=0, RX_VALID unchanged, spi_csn_o=1.
//  - New transfer while RX_VALID=1: allowed; the old byte is overwritten at completion.
//  - DATA read on the completion edge: the read returns the old byte and RX_VALID ends at 1 (set wins over clear).
//  - rst_i mid-transfer: immediate return to reset values, including spi_csn_o=1.
//  CDIV=0: SCK = clk/2; CDIV=255: SCK = clk/512.
// CONFIGURATION
//  CELLRV32_SPI_HOST_IRQ_EN defined:
//  - irq_o is registered: irq_o = EN & IRQ_EN & RX_VALID.
//  - It rises 1 cycle after RX_VALID sets and falls 1 cycle after the DATA read clears RX_VALID.
//  CELLRV32_SPI_HOST_IRQ_EN undefined: irq_o tied 0; CTRL[4] is not stored and reads 0.
// TESTING
//  1 Reset: assert rst_i mid-transfer -> next cycle csn=1, clk=0, dat_o=0, ack=0, irq=0; CTRL reads 0x0.
//  2 Mode 0, CDIV=0, loopback MOSI->MISO: CTRL=0x0000_0009, DATA=0xA5 -> 8 SCK rising edges, BUSY 16 cycles;
//    DATA reads 0x0000_00A5; CTRL[31] is 0 after the read.
//  3 Mode 3, CDIV=3, device model replies 0x3C: CTRL=0x0000_030F, DATA=0x81 -> SCK idles high, period 8 clks;
//    device sees 0x81, BUSY 64 cycles, DATA reads 0x3C.
//  4 Write DATA=0xFF during a transfer of 0x5A (loopback) -> result 0x5A; exactly 8 SCK pulses; no second transfer.
//  5 Clear EN after 3 bits -> next cycle BUSY=0, spi_clk_o=0, csn=1, RX_VALID=0; a new transfer after re-enable is correct.
//  6 Macro defined, IRQ_EN=1: transfer completes -> irq_o=1 one cycle after RX_VALID; DATA read -> irq_o=0.
//    Macro undefined: irq_o is always 0.

Source files
------------

// File: rtl/cellrv32_spi_host.sv
// cellrv32_spi_host: bus-mapped SPI host, one byte per transfer, MSB first.
// Define CELLRV32_SPI_HOST_IRQ_EN to store CTRL[4] and drive a registered irq_o.
module cellrv32_spi_host #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFA8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        spi_clk_o,
  output logic        spi_csn_o,
  output logic        spi_dat_o,
  input  logic        spi_dat_i,
  output logic        irq_o
);
  typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;
  state_t state_q, state_d;
  logic en_q, en_d, cpha_q, cpha_d, cpol_q, cpol_d, csen_q, csen_d, irqen_q;
  logic [7:0] cdiv_q, cdiv_d, cdiv_l_q, cdiv_l_d;
  logic cpha_l_q, cpha_l_d, cpol_l_q, cpol_l_d;
  logic [7:0] sreg_q, sreg_d, rx_q, rx_d, presc_q, presc_d;
  logic [2:0] cnt_q, cnt_d;
  logic rxv_q, rxv_d, samp_q, samp_d, sck_q, sck_d, csn_q, csn_d, dout_q, dout_d, ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic sel_ctrl, sel_data, busy, last, wr_ctrl;
  logic [7:0] rx_next;
  logic unused_bits;
  assign sel_ctrl = addr_i == BASE_ADDR;
  assign sel_data = addr_i == BASE_ADDR + 32'd4;
  assign wr_ctrl = wren_i & sel_ctrl;
  assign busy = state_q != IDLE;
  assign last = presc_q == cdiv_l_q;
  assign rx_next = {sreg_q[6:0], cpha_l_q ? spi_dat_i : samp_q};
  assign unused_bits = ^{data_i[31:16], data_i[7:4]};
  always_comb begin
    state_d = state_q;
    cpha_l_d = cpha_l_q;
    cpol_l_d = cpol_l_q;
    cdiv_l_d = cdiv_l_q;
    sreg_d = sreg_q;
    rx_d = rx_q;
    cnt_d = cnt_q;
    samp_d = samp_q;
    dout_d = dout_q;
    en_d = wr_ctrl ? data_i[0] : en_q;
    cpha_d = wr_ctrl ? data_i[1] : cpha_q;
    cpol_d = wr_ctrl ? data_i[2] : cpol_q;
    csen_d = wr_ctrl ? data_i[3] : csen_q;
    cdiv_d = wr_ctrl ? data_i[15:8] : cdiv_q;
    ack_d = (rden_i | wren_i) & (sel_ctrl | sel_data);
    rdata_d = (rden_i & sel_ctrl) ? {rxv_q, busy, 14'h0, cdiv_q, 3'h0, irqen_q, csen_q, cpol_q, cpha_q, en_q} :
              (rden_i & sel_data) ? {24'h0, rx_q} : 32'h0;
    rxv_d = (rden_i & sel_data) ? 1'b0 : rxv_q;
    presc_d = (busy & ~last) ? presc_q + 8'd1 : 8'd0;
    sck_d = busy ? sck_q : (en_d & cpol_d);
    case (state_q)
      IDLE: if (wren_i & sel_data & en_q) begin
        state_d = LEAD;
        sreg_d = data_i[7:0];
        cpha_l_d = cpha_q;
        cpol_l_d = cpol_q;
        cdiv_l_d = cdiv_q;
        cnt_d = 3'd0;
        dout_d = cpha_q ? dout_q : data_i[7];
      end
      LEAD: if (last) begin
        state_d = TRAIL;
        sck_d = ~cpol_l_q;
        dout_d = cpha_l_q ? sreg_q[7] : dout_q;
        samp_d = cpha_l_q ? samp_q : spi_dat_i;
      end
      TRAIL: if (last) begin
        sck_d = cpol_l_q;
        sreg_d = rx_next;
        dout_d = (!cpha_l_q && cnt_q != 3'd7) ? sreg_q[6] : dout_q;
        state_d = (cnt_q == 3'd7) ? IDLE : LEAD;
        cnt_d = cnt_q + 3'd1;
        rx_d = (cnt_q == 3'd7) ? rx_next : rx_q;
        rxv_d = (cnt_q == 3'd7) | rxv_d;
      end
      default: state_d = IDLE;
    endcase
    // Disabling mid-transfer aborts on the same edge that clears EN.
    if (busy && !en_d) begin
      state_d = IDLE;
      sck_d = 1'b0;
    end
    csn_d = ~(en_d & csen_d);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      {en_q, cpha_q, cpol_q, csen_q, cdiv_q} <= '0;
      {cpha_l_q, cpol_l_q, cdiv_l_q} <= '0;
      {sreg_q, rx_q, presc_q, cnt_q} <= '0;
      {rxv_q, samp_q, sck_q, dout_q, ack_q} <= '0;
      csn_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      {en_q, cpha_q, cpol_q, csen_q, cdiv_q} <= {en_d, cpha_d, cpol_d, csen_d, cdiv_d};
      {cpha_l_q, cpol_l_q, cdiv_l_q} <= {cpha_l_d, cpol_l_d, cdiv_l_d};
      {sreg_q, rx_q, presc_q, cnt_q} <= {sreg_d, rx_d, presc_d, cnt_d};
      {rxv_q, samp_q, sck_q, dout_q, ack_q} <= {rxv_d, samp_d, sck_d, dout_d, ack_d};
      csn_q <= csn_d;
      rdata_q <= rdata_d;
    end
  end
`ifdef CELLRV32_SPI_HOST_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irqen_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      irqen_q <= wr_ctrl ? data_i[4] : irqen_q;
      irq_q <= en_q & irqen_q & rxv_q;
    end
  end
  assign irq_o = irq_q;
`else
  assign irqen_q = 1'b0;
  assign irq_o = 1'b0;
`endif
  assign data_o = rdata_q;
  assign ack_o = ack_q;
  assign spi_clk_o = sck_q;
  assign spi_csn_o = csn_q;
  assign spi_dat_o = dout_q;
endmodule
